// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: on an exception it freezes the pipeline, writes
// mepc, mcause and mtval through the CSR write port one per cycle, then jumps to mtvec.
module trap_sequencer #(
    parameter logic [11:0] ADDR_MEPC   = 12'h341,
    parameter logic [11:0] ADDR_MCAUSE = 12'h342,
    parameter logic [11:0] ADDR_MTVAL  = 12'h343,
    parameter logic [31:0] CAUSE_ROM   = 32'd1,
    parameter logic [31:0] CAUSE_OP    = 32'd2,
    parameter logic [31:0] CAUSE_RAM   = 32'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [15:0] rom_addr,
    input  logic [15:0] ram_addr,
    input  logic        exc_rom,
    input  logic        exc_op,
    input  logic        exc_ram,
    input  logic        mret,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        csr_w_i,
    input  logic [11:0] csr_i,
    input  logic [31:0] wd_i,
    output logic        csr_w_o,
    output logic [11:0] csr_o,
    output logic [31:0] wd_o,
    output logic        stall,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic        trap_active
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SAVE_EPC   = 3'd1,
        SAVE_CAUSE = 3'd2,
        SAVE_TVAL  = 3'd3,
        JUMP       = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic        trap_active_q, trap_active_d;

    logic        exc_any_s;
    logic        csr_w_s;
    logic [11:0] csr_s;
    logic [31:0] wd_s;
    logic        stall_s;
    logic        pc_load_s;
    logic [31:0] pc_target_s;

    // ROM faults outrank opcode faults, which outrank RAM faults.
    function automatic logic [31:0] sel_cause(input logic rom_f, input logic op_f);
        logic [31:0] c;
        if (rom_f) begin
            c = CAUSE_ROM;
        end else if (op_f) begin
            c = CAUSE_OP;
        end else begin
            c = CAUSE_RAM;
        end
        return c;
    endfunction

    function automatic logic [31:0] sel_tval(input logic rom_f, input logic op_f,
                                             input logic [15:0] pc,
                                             input logic [31:0] ins,
                                             input logic [15:0] daddr);
        logic [31:0] v;
        if (rom_f) begin
            v = {16'h0000, pc};
        end else if (op_f) begin
            v = ins;
        end else begin
            v = {16'h0000, daddr};
        end
        return v;
    endfunction

    assign exc_any_s = exc_rom | exc_op | exc_ram;

    // Next-state, trap-record latching and unmasked port values.
    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        csr_w_s     = 1'b0;
        csr_s       = 12'h000;
        wd_s        = 32'h0000_0000;
        stall_s     = 1'b0;
        pc_load_s   = 1'b0;
        pc_target_s = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (exc_any_s) begin
                    // The faulting instruction's own CSR write and any mret are dropped.
                    stall_s = 1'b1;
                    epc_d   = {16'h0000, rom_addr};
                    cause_d = sel_cause(exc_rom, exc_op);
                    tval_d  = sel_tval(exc_rom, exc_op, rom_addr, instr, ram_addr);
                    state_d = SAVE_EPC;
                end else begin
                    csr_w_s = csr_w_i;
                    csr_s   = csr_i;
                    wd_s    = wd_i;
                    if (mret) begin
                        pc_load_s   = 1'b1;
                        pc_target_s = mepc;
                    end else begin
                        pc_load_s   = 1'b0;
                        pc_target_s = 32'h0000_0000;
                    end
                end
            end
            SAVE_EPC: begin
                csr_w_s = 1'b1;
                csr_s   = ADDR_MEPC;
                wd_s    = epc_q;
                stall_s = 1'b1;
                state_d = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                csr_w_s = 1'b1;
                csr_s   = ADDR_MCAUSE;
                wd_s    = cause_q;
                stall_s = 1'b1;
                state_d = SAVE_TVAL;
            end
            SAVE_TVAL: begin
                csr_w_s = 1'b1;
                csr_s   = ADDR_MTVAL;
                wd_s    = tval_q;
                stall_s = 1'b1;
                state_d = JUMP;
            end
            JUMP: begin
                stall_s     = 1'b1;
                pc_load_s   = 1'b1;
                pc_target_s = mtvec;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        trap_active_d = (state_d != IDLE);
    end

    // Port drive: every combinational output is held low while reset is asserted.
    always_comb begin
        if (rst) begin
            csr_w_o   = 1'b0;
            csr_o     = 12'h000;
            wd_o      = 32'h0000_0000;
            stall     = 1'b0;
            pc_load   = 1'b0;
            pc_target = 32'h0000_0000;
        end else begin
            csr_w_o   = csr_w_s;
            csr_o     = csr_s;
            wd_o      = wd_s;
            stall     = stall_s;
            pc_load   = pc_load_s;
            pc_target = pc_target_s;
        end
    end

    // State, trap record and trap_active registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            epc_q         <= 32'h0000_0000;
            cause_q       <= 32'h0000_0000;
            tval_q        <= 32'h0000_0000;
            trap_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            cause_q       <= cause_d;
            tval_q        <= tval_d;
            trap_active_q <= trap_active_d;
        end
    end

    assign trap_active = trap_active_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus random traffic,
// checked against a transaction-queue model of the pending CSR writes and redirect.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [15:0] rom_addr, ram_addr;
    logic        exc_rom, exc_op, exc_ram, mret;
    logic [31:0] mtvec, mepc;
    logic        csr_w_i;
    logic [11:0] csr_i;
    logic [31:0] wd_i;
    logic        csr_w_o;
    logic [11:0] csr_o;
    logic [31:0] wd_o;
    logic        stall, pc_load;
    logic [31:0] pc_target;
    logic        trap_active;

    int checks = 0;
    int errors = 0;

    trap_sequencer dut (
        .clk(clk), .rst(rst), .instr(instr), .rom_addr(rom_addr), .ram_addr(ram_addr),
        .exc_rom(exc_rom), .exc_op(exc_op), .exc_ram(exc_ram), .mret(mret),
        .mtvec(mtvec), .mepc(mepc), .csr_w_i(csr_w_i), .csr_i(csr_i), .wd_i(wd_i),
        .csr_w_o(csr_w_o), .csr_o(csr_o), .wd_o(wd_o), .stall(stall),
        .pc_load(pc_load), .pc_target(pc_target), .trap_active(trap_active)
    );

    always #5 clk = ~clk;

    // Reference model: an outstanding trap is a queue of CSR writes followed by a jump.
    typedef struct {
        bit          jump;
        logic [11:0] addr;
        logic [31:0] data;
    } op_t;
    op_t pend[$];

    logic        e_w, e_stall, e_pcl, e_ta, e_av, e_tv;
    logic [11:0] e_addr;
    logic [31:0] e_wd, e_tgt;

    // Observation log of the CSR writes and redirects seen in a scenario.
    logic [11:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    logic [31:0] jlog[$];

    task automatic model_eval();
        e_w = 1'b0; e_addr = 12'h0; e_wd = 32'h0; e_stall = 1'b0;
        e_pcl = 1'b0; e_tgt = 32'h0; e_ta = 1'b0; e_av = 1'b0; e_tv = 1'b0;
        if (rst) begin
            e_av = 1'b1; e_tv = 1'b1;
        end else if (pend.size() > 0) begin
            e_ta = 1'b1; e_stall = 1'b1;
            if (pend[0].jump) begin
                e_pcl = 1'b1; e_tv = 1'b1; e_tgt = mtvec;
            end else begin
                e_w = 1'b1; e_av = 1'b1; e_addr = pend[0].addr; e_wd = pend[0].data;
            end
        end else if (exc_rom || exc_op || exc_ram) begin
            e_stall = 1'b1;
        end else begin
            e_w = csr_w_i; e_av = 1'b1; e_addr = csr_i; e_wd = wd_i;
            if (mret) begin
                e_pcl = 1'b1; e_tv = 1'b1; e_tgt = mepc;
            end
        end
    endtask

    task automatic model_clock();
        logic [31:0] cause, tval;
        if (rst) begin
            pend.delete();
        end else if (pend.size() > 0) begin
            void'(pend.pop_front());
        end else if (exc_rom || exc_op || exc_ram) begin
            if (exc_rom)     begin cause = 32'd1; tval = {16'h0, rom_addr}; end
            else if (exc_op) begin cause = 32'd2; tval = instr; end
            else             begin cause = 32'd5; tval = {16'h0, ram_addr}; end
            pend.push_back('{1'b0, 12'h341, {16'h0, rom_addr}});
            pend.push_back('{1'b0, 12'h342, cause});
            pend.push_back('{1'b0, 12'h343, tval});
            pend.push_back('{1'b1, 12'h000, 32'h0});
        end
    endtask

    function automatic logic [79:0] exp_vec();
        return {e_w, e_av ? e_addr : 12'h0, e_av ? e_wd : 32'h0, e_stall, e_pcl,
                e_tv ? e_tgt : 32'h0, e_ta};
    endfunction

    function automatic logic [79:0] obs_vec();
        return {csr_w_o, e_av ? csr_o : 12'h0, e_av ? wd_o : 32'h0, stall, pc_load,
                e_tv ? pc_target : 32'h0, trap_active};
    endfunction

    task automatic settle();
        #1;
        model_eval();
        if (csr_w_o === 1'b1) begin
            wlog_a.push_back(csr_o); wlog_d.push_back(wd_o);
        end
        if (pc_load === 1'b1) jlog.push_back(pc_target);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        exc_rom = 1'b0; exc_op = 1'b0; exc_ram = 1'b0; mret = 1'b0; csr_w_i = 1'b0;
    endtask

    task automatic clear_logs();
        wlog_a.delete(); wlog_d.delete(); jlog.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 32'h0; rom_addr = 16'h0; ram_addr = 16'h0;
        mtvec = 32'h100; mepc = 32'h40; csr_i = 12'h005; wd_i = 32'd7;
        quiet_inputs();
        csr_w_i = 1'b1; mret = 1'b1;
        settle();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        quiet_inputs();
    endtask

    // Runs an exception-triggered trap; the first cycle carries the fault inputs.
    task automatic run_trap(input string name, input int cycles, input int pulse_cycle);
        clear_logs();
        for (int c = 0; c < cycles; c++) begin
            if (c == 1) quiet_inputs();
            if (pulse_cycle >= 0 && c == pulse_cycle) exc_op = 1'b1;
            if (pulse_cycle >= 0 && c == pulse_cycle + 1) exc_op = 1'b0;
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL %s_cycle%0d: got %h expected %h", name, c, obs_vec(), exp_vec());
            end
            cyc();
        end
        quiet_inputs();
    endtask

    task automatic test_illegal_opcode();
        instr = 32'h0050_207F; rom_addr = 16'd24; mtvec = 32'h100;
        exc_op = 1'b1; csr_w_i = 1'b1; csr_i = 12'h300; wd_i = 32'hDEAD;
        settle();
        checks++;
        if ({csr_w_o, stall, pc_load} !== 3'b010) begin
            errors++; $display("FAIL op_exc_cycle: got w/stall/pcl=%b required 010", {csr_w_o, stall, pc_load});
        end
        run_trap("op", 6, -1);
        checks++;
        if (wlog_a.size() != 3 || wlog_a[0] !== 12'h341 || wlog_d[0] !== 32'd24
            || wlog_a[1] !== 12'h342 || wlog_d[1] !== 32'd2
            || wlog_a[2] !== 12'h343 || wlog_d[2] !== 32'h0050_207F) begin
            errors++; $display("FAIL op_writes: got %0d writes first %h<=%h", wlog_a.size(),
                               wlog_a.size() > 0 ? wlog_a[0] : 12'h0, wlog_a.size() > 0 ? wlog_d[0] : 32'h0);
        end
        checks++;
        if (jlog.size() != 1 || jlog[0] !== 32'h100) begin
            errors++; $display("FAIL op_jump: got %0d redirects, required one to 00000100", jlog.size());
        end
    endtask

    task automatic test_ram_fault();
        rom_addr = 16'd32; ram_addr = 16'd76; exc_ram = 1'b1;
        run_trap("ram", 6, -1);
        checks++;
        if (wlog_a.size() != 3 || wlog_d[0] !== 32'd32 || wlog_d[1] !== 32'd5 || wlog_d[2] !== 32'd76) begin
            errors++; $display("FAIL ram_writes: got %0d writes, required 32,5,76", wlog_a.size());
        end
    endtask

    task automatic test_simultaneous();
        rom_addr = 16'd112; ram_addr = 16'd76; exc_rom = 1'b1; exc_ram = 1'b1;
        run_trap("simul", 7, 2);
        checks++;
        if (wlog_a.size() != 3 || wlog_d[1] !== 32'd1 || wlog_d[2] !== 32'd112) begin
            errors++; $display("FAIL simul_writes: got %0d writes, required mcause=1 mtval=112", wlog_a.size());
        end
    endtask

    task automatic test_passthrough_mret();
        csr_w_i = 1'b1; csr_i = 12'h005; wd_i = 32'd100;
        settle();
        checks++;
        if ({csr_w_o, csr_o, wd_o, stall, pc_load} !== {1'b1, 12'h005, 32'd100, 1'b0, 1'b0}) begin
            errors++; $display("FAIL passthrough: got %b %h %0d stall=%b", csr_w_o, csr_o, wd_o, stall);
        end
        cyc();
        quiet_inputs(); mret = 1'b1; mepc = 32'h40;
        settle();
        checks++;
        if ({pc_load, pc_target, stall} !== {1'b1, 32'h40, 1'b0}) begin
            errors++; $display("FAIL mret: got pcl=%b tgt=%h required 1 00000040", pc_load, pc_target);
        end
        cyc();
        quiet_inputs();
        settle();
        checks++;
        if ({trap_active, stall, pc_load} !== 3'b000) begin
            errors++; $display("FAIL mret_no_state: got %b required 000", {trap_active, stall, pc_load});
        end
    endtask

    task automatic test_priority_mret();
        mepc = 32'h40; mtvec = 32'h200; rom_addr = 16'd8; instr = 32'hFFFF_FFFF;
        mret = 1'b1; exc_op = 1'b1;
        settle();
        checks++;
        if ({pc_load, stall} !== 2'b01) begin
            errors++; $display("FAIL prio_mret: got pcl/stall=%b required 01", {pc_load, stall});
        end
        run_trap("prio", 6, -1);
        checks++;
        if (jlog.size() != 1 || jlog[0] !== 32'h200) begin
            errors++; $display("FAIL prio_target: got %0d redirects, required one to 00000200", jlog.size());
        end
    endtask

    task automatic test_reset_mid();
        rom_addr = 16'd60; exc_op = 1'b1; instr = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rstmid_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            cyc();
            quiet_inputs();
        end
        #2;
        rst = 1'b1;
        pend.delete();
        settle();
        checks++;
        if ({csr_w_o, csr_o, wd_o, stall, pc_load, pc_target, trap_active} !== 79'h0) begin
            errors++; $display("FAIL rstmid_async: got w=%b stall=%b pcl=%b ta=%b required all 0",
                               csr_w_o, stall, pc_load, trap_active);
        end
        cyc();
        rst = 1'b0;
        clear_logs();
        for (int c = 0; c < 5; c++) begin
            settle();
            cyc();
        end
        checks++;
        if (wlog_a.size() != 0 || jlog.size() != 0) begin
            errors++; $display("FAIL rstmid_after: got %0d writes %0d redirects, required 0 0",
                               wlog_a.size(), jlog.size());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            instr = $urandom; rom_addr = 16'($urandom); ram_addr = 16'($urandom);
            mtvec = $urandom; mepc = $urandom; csr_i = 12'($urandom); wd_i = $urandom;
            exc_rom = ($urandom_range(0, 11) == 0); exc_op = ($urandom_range(0, 11) == 0);
            exc_ram = ($urandom_range(0, 11) == 0); mret = ($urandom_range(0, 5) == 0);
            csr_w_i = 1'($urandom);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", c, obs_vec(), exp_vec());
            end
            cyc();
        end
        quiet_inputs();
    endtask

    initial begin
        test_reset();
        test_illegal_opcode();
        test_ram_fault();
        test_simultaneous();
        test_passthrough_mret();
        test_priority_mret();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
